// File: rtl/time_entry_ctrl_if.sv
// Overwrite bus between the time-entry front end (master) and the digital clock (slave):
// the running time flows in, the committed time and its one-cycle load strobe flow out.
interface time_entry_ctrl_if;
    logic [16:0] cur_time;
    logic [16:0] time_in;
    logic        time_ow;

    modport master (input cur_time, output time_in, output time_ow);
    modport slave  (output cur_time, input time_in, input time_ow);
endinterface

// File: rtl/time_entry_ctrl.sv
// Digit-by-digit time entry for the digital clock: capture, BCD edit, validate, overwrite.
// Optional cursor blink is built only when TIME_ENTRY_BLINK_EN is defined.
module time_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int BLINK_CYCLES   = 250
) (
    input  logic                clk,
    input  logic                time_reset_n,
    input  logic                entry_start,
    input  logic                digit_inc,
    input  logic                digit_dec,
    input  logic                digit_next,
    input  logic                entry_cancel,
    time_entry_ctrl_if.master   bus,
    output logic                edit_active,
    output logic [2:0]          cursor,
    output logic [3:0]          ed_hr_10s,
    output logic [3:0]          ed_hr_1s,
    output logic [3:0]          ed_min_10s,
    output logic [3:0]          ed_min_1s,
    output logic [3:0]          ed_sec_10s,
    output logic [3:0]          ed_sec_1s,
    output logic                entry_timeout,
    output logic                cursor_blank
);
    typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    state_t          state_reg;
    logic [4:0]      btn_prev_reg;
    logic [4:0]      btn;
    logic [4:0]      btn_edge;
    logic [3:0]      digit_reg  [0:5];
    logic [3:0]      digit_max  [0:5];
    logic [3:0]      digit_step [0:5];
    logic [3:0]      load_digit [0:5];
    logic [2:0]      cursor_reg;
    logic [TO_W-1:0] timeout_cnt_reg;
    logic [16:0]     time_in_reg;
    logic            time_ow_reg;
    logic            edit_active_reg;
    logic            entry_timeout_reg;
    logic            start_edge, inc_edge, dec_edge, next_edge, cancel_edge;
    logic            step_edge, accept_edge;
    logic [4:0]      hour_v;
    logic [5:0]      min_v, sec_v;
    logic [7:0]      hr_bcd, min_bcd, sec_bcd;

    function automatic logic [3:0] step_digit(input logic [3:0] v, input logic [3:0] vmax,
                                              input logic up);
        if (up)
            return (v >= vmax) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? vmax : v - 4'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 6'(tens) * 6'd10 + 6'(ones);
    endfunction

    assign btn         = {entry_cancel, digit_next, digit_dec, digit_inc, entry_start};
    assign btn_edge    = btn & ~btn_prev_reg;
    assign start_edge  = btn_edge[0];
    assign inc_edge    = btn_edge[1];
    assign dec_edge    = btn_edge[2];
    assign next_edge   = btn_edge[3];
    assign cancel_edge = btn_edge[4];
    // Simultaneous inc and dec cancel each other out and do not count as activity.
    assign step_edge   = inc_edge ^ dec_edge;
    assign accept_edge = cancel_edge | next_edge | step_edge;

    always_comb begin
        hour_v  = (bus.cur_time[16:12] > 5'd23) ? 5'd0 : bus.cur_time[16:12];
        min_v   = (bus.cur_time[11:6]  > 6'd59) ? 6'd0 : bus.cur_time[11:6];
        sec_v   = (bus.cur_time[5:0]   > 6'd59) ? 6'd0 : bus.cur_time[5:0];
        hr_bcd  = to_bcd({1'b0, hour_v});
        min_bcd = to_bcd(min_v);
        sec_bcd = to_bcd(sec_v);
        load_digit[0] = hr_bcd[7:4];
        load_digit[1] = hr_bcd[3:0];
        load_digit[2] = min_bcd[7:4];
        load_digit[3] = min_bcd[3:0];
        load_digit[4] = sec_bcd[7:4];
        load_digit[5] = sec_bcd[3:0];
    end

    always_comb begin
        digit_max[0] = 4'd2;
        digit_max[1] = (digit_reg[0] == 4'd2) ? 4'd3 : 4'd9;
        digit_max[2] = 4'd5;
        digit_max[3] = 4'd9;
        digit_max[4] = 4'd5;
        digit_max[5] = 4'd9;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_step
            assign digit_step[gi] = step_digit(digit_reg[gi], digit_max[gi], inc_edge);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!time_reset_n) begin
            state_reg         <= IDLE;
            btn_prev_reg      <= 5'b11111;
            cursor_reg        <= 3'd0;
            timeout_cnt_reg   <= '0;
            time_in_reg       <= 17'd0;
            time_ow_reg       <= 1'b0;
            edit_active_reg   <= 1'b0;
            entry_timeout_reg <= 1'b0;
            for (int i = 0; i < 6; i++)
                digit_reg[i] <= 4'd0;
        end else begin
            btn_prev_reg      <= btn;
            time_ow_reg       <= 1'b0;
            entry_timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        state_reg       <= LOAD;
                        edit_active_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 6; i++)
                        digit_reg[i] <= load_digit[i];
                    cursor_reg      <= 3'd0;
                    timeout_cnt_reg <= '0;
                    state_reg       <= EDIT;
                end
                EDIT: begin
                    if (accept_edge)
                        timeout_cnt_reg <= '0;
                    else if (timeout_cnt_reg != TO_LAST)
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;

                    if (cancel_edge) begin
                        state_reg       <= IDLE;
                        edit_active_reg <= 1'b0;
                    end else if (next_edge) begin
                        if (cursor_reg == 3'd5) begin
                            state_reg       <= COMMIT;
                            edit_active_reg <= 1'b0;
                            time_ow_reg     <= 1'b1;
                            time_in_reg     <= {5'(to_bin(digit_reg[0], digit_reg[1])),
                                                to_bin(digit_reg[2], digit_reg[3]),
                                                to_bin(digit_reg[4], digit_reg[5])};
                        end else begin
                            cursor_reg <= cursor_reg + 3'd1;
                        end
                    end else if (step_edge) begin
                        digit_reg[cursor_reg] <= digit_step[cursor_reg];
                        // Moving the tens-of-hours to 2 must not leave an hour above 23.
                        if (cursor_reg == 3'd0 && digit_step[0] == 4'd2 && digit_reg[1] > 4'd3)
                            digit_reg[1] <= 4'd3;
                    end else if (timeout_cnt_reg == TO_LAST) begin
                        state_reg         <= IDLE;
                        edit_active_reg   <= 1'b0;
                        entry_timeout_reg <= 1'b1;
                    end
                end
                COMMIT: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef TIME_ENTRY_BLINK_EN
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    logic [BL_W-1:0] blink_cnt_reg;
    logic            blank_reg;

    always_ff @(posedge clk) begin
        if (!time_reset_n) begin
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
        end else if (state_reg != EDIT || accept_edge) begin
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
        end else if (blink_cnt_reg == BL_LAST) begin
            blink_cnt_reg <= '0;
            blank_reg     <= ~blank_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Gate with edit_active so the blank is dropped the moment the entry ends.
    assign cursor_blank = blank_reg & edit_active_reg;
`else
    // Always 0 for any legal BLINK_CYCLES; the reference keeps the parameter in use.
    assign cursor_blank = (BLINK_CYCLES < 0);
`endif

    assign bus.time_in   = time_in_reg;
    assign bus.time_ow   = time_ow_reg;
    assign edit_active   = edit_active_reg;
    assign cursor        = cursor_reg;
    assign entry_timeout = entry_timeout_reg;
    assign ed_hr_10s     = digit_reg[0];
    assign ed_hr_1s      = digit_reg[1];
    assign ed_min_10s    = digit_reg[2];
    assign ed_min_1s     = digit_reg[3];
    assign ed_sec_10s    = digit_reg[4];
    assign ed_sec_1s     = digit_reg[5];
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Scenario bench for time_entry_ctrl: expected overwrite words are queued when an entry is
// completed and popped by a monitor whenever time_ow fires.
`timescale 1ns/1ps
module tb_time_entry_ctrl;
    localparam int B_START  = 0;
    localparam int B_INC    = 1;
    localparam int B_DEC    = 2;
    localparam int B_NEXT   = 3;
    localparam int B_CANCEL = 4;

    logic        clk = 1'b0;
    logic        time_reset_n;
    logic        entry_start, digit_inc, digit_dec, digit_next, entry_cancel;
    logic        edit_active, entry_timeout, cursor_blank;
    logic [2:0]  cursor;
    logic [3:0]  ed_hr_10s, ed_hr_1s, ed_min_10s, ed_min_1s, ed_sec_10s, ed_sec_1s;
    logic [23:0] digits;
    logic [16:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ow_count = 0;

    always #5 clk = ~clk;

    time_entry_ctrl_if bus();

    time_entry_ctrl #(.TIMEOUT_CYCLES(16), .BLINK_CYCLES(4)) dut (
        .clk(clk), .time_reset_n(time_reset_n),
        .entry_start(entry_start), .digit_inc(digit_inc), .digit_dec(digit_dec),
        .digit_next(digit_next), .entry_cancel(entry_cancel), .bus(bus),
        .edit_active(edit_active), .cursor(cursor),
        .ed_hr_10s(ed_hr_10s), .ed_hr_1s(ed_hr_1s), .ed_min_10s(ed_min_10s),
        .ed_min_1s(ed_min_1s), .ed_sec_10s(ed_sec_10s), .ed_sec_1s(ed_sec_1s),
        .entry_timeout(entry_timeout), .cursor_blank(cursor_blank)
    );

    assign digits = {ed_hr_10s, ed_hr_1s, ed_min_10s, ed_min_1s, ed_sec_10s, ed_sec_1s};

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.time_ow === 1'b1) begin
            ow_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: time_in=%h with nothing expected", bus.time_in);
            end else begin
                logic [16:0] exp_w;
                exp_w = exp_q.pop_front();
                if (bus.time_in !== exp_w) begin
                    n_fail++;
                    $display("FAIL write_value: time_in=%h expected %h", bus.time_in, exp_w);
                end else begin
                    $display("write time_in=%h ok", bus.time_in);
                end
            end
        end
    end

    task automatic drive_btn(input int b, input logic v);
        case (b)
            B_START:  entry_start  = v;
            B_INC:    digit_inc    = v;
            B_DEC:    digit_dec    = v;
            B_NEXT:   digit_next   = v;
            B_CANCEL: entry_cancel = v;
            default: ;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        drive_btn(b, 1'b1);
        @(negedge clk);
        drive_btn(b, 1'b0);
    endtask

    task automatic press_n(input int b, input int n);
        for (int i = 0; i < n; i++)
            press(b);
    endtask

    // Returns in the first EDIT cycle with the captured digits visible.
    task automatic start_entry(input logic [16:0] t);
        bus.cur_time = t;
        press(B_START);
        @(negedge clk);
    endtask

    task automatic test_reset;
        time_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.time_in, bus.time_ow, edit_active, cursor} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {time_in,ow,active,cursor}=%h expected 0",
                     {bus.time_in, bus.time_ow, edit_active, cursor});
        end
        n_checks++;
        if ({digits, entry_timeout, cursor_blank} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_digits: {digits,timeout,blank}=%h expected 0",
                     {digits, entry_timeout, cursor_blank});
        end
        time_reset_n = 1'b1;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_basic;
        start_entry(17'h0C8B8);
        n_checks++;
        if (digits !== 24'h123456) begin
            n_fail++;
            $display("FAIL basic_load: digits=%h expected 123456", digits);
        end
        press(B_INC);
        n_checks++;
        if (digits !== 24'h223456) begin
            n_fail++;
            $display("FAIL basic_inc: digits=%h expected 223456", digits);
        end
        press_n(B_NEXT, 5);
        n_checks++;
        if (cursor !== 3'd5) begin
            n_fail++;
            $display("FAIL basic_cursor: cursor=%0d expected 5", cursor);
        end
        exp_q.push_back(17'h168B8);
        press(B_NEXT);
        n_checks++;
        if (bus.time_ow !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ow_latency: time_ow=%b expected 1", bus.time_ow);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.time_ow, edit_active, bus.time_in, digits} !== {2'b00, 17'h168B8, 24'h223456}) begin
            n_fail++;
            $display("FAIL basic_after: ow=%b active=%b time_in=%h digits=%h expected 0 0 168b8 223456",
                     bus.time_ow, edit_active, bus.time_in, digits);
        end
        $display("basic edit/commit done");
    endtask

    task automatic test_clamp;
        start_entry(17'h13000);
        press(B_INC);
        n_checks++;
        if (digits !== 24'h230000) begin
            n_fail++;
            $display("FAIL clamp_hr: digits=%h expected 230000", digits);
        end
        exp_q.push_back(17'h17000);
        press_n(B_NEXT, 6);
        @(negedge clk);
        $display("hour clamp done");
    endtask

    task automatic test_wrap;
        start_entry(17'h0CC80);
        press_n(B_NEXT, 2);
        press(B_INC);
        n_checks++;
        if (digits !== 24'h120000) begin
            n_fail++;
            $display("FAIL wrap_inc: digits=%h expected 120000", digits);
        end
        press_n(B_NEXT, 3);
        press(B_DEC);
        n_checks++;
        if (digits !== 24'h120009) begin
            n_fail++;
            $display("FAIL wrap_dec: digits=%h expected 120009", digits);
        end
        @(negedge clk);
        digit_inc = 1'b1;
        digit_dec = 1'b1;
        @(negedge clk);
        digit_inc = 1'b0;
        digit_dec = 1'b0;
        @(negedge clk);
        n_checks++;
        if (digits !== 24'h120009) begin
            n_fail++;
            $display("FAIL wrap_incdec: digits=%h expected 120009", digits);
        end
        exp_q.push_back(17'h0C009);
        press(B_NEXT);
        @(negedge clk);
        $display("digit wrap done");
    endtask

    task automatic test_abort;
        int ow_before;
        int n;
        ow_before = ow_count;
        start_entry(17'h0C8B8);
        press_n(B_NEXT, 3);
        press(B_CANCEL);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({edit_active, bus.time_in} !== {1'b0, 17'h0C009} || ow_count != ow_before) begin
            n_fail++;
            $display("FAIL cancel: active=%b time_in=%h writes=%0d expected 0 0c009 %0d",
                     edit_active, bus.time_in, ow_count, ow_before);
        end
        bus.cur_time = 17'h0C8B8;
        press(B_START);
        n = 0;
        while (edit_active === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 16 || entry_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: active cycles=%0d timeout=%b expected 16 1", n, entry_timeout);
        end
        @(negedge clk);
        n_checks++;
        if (entry_timeout !== 1'b0 || ow_count != ow_before) begin
            n_fail++;
            $display("FAIL timeout_pulse: timeout=%b writes=%0d expected 0 %0d",
                     entry_timeout, ow_count, ow_before);
        end
        $display("abort paths done");
    endtask

    task automatic test_blink;
`ifdef TIME_ENTRY_BLINK_EN
        logic [5:0] seq;
        logic [4:0] seq2;
        start_entry(17'h0C8B8);
        for (int i = 0; i < 6; i++) begin
            seq[5-i] = cursor_blank;
            @(negedge clk);
        end
        n_checks++;
        if (seq !== 6'b000011) begin
            n_fail++;
            $display("FAIL blink_toggle: seq=%b expected 000011", seq);
        end
        press(B_INC);
        for (int i = 0; i < 5; i++) begin
            seq2[4-i] = cursor_blank;
            @(negedge clk);
        end
        n_checks++;
        if (seq2 !== 5'b00001) begin
            n_fail++;
            $display("FAIL blink_restart: seq=%b expected 00001", seq2);
        end
        press(B_CANCEL);
        n_checks++;
        if (cursor_blank !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_idle: cursor_blank=%b expected 0", cursor_blank);
        end
`else
        logic seen;
        seen = 1'b0;
        start_entry(17'h0C8B8);
        for (int i = 0; i < 8; i++) begin
            seen = seen | cursor_blank;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_off: cursor_blank seen=%b expected 0", seen);
        end
        press(B_CANCEL);
`endif
        @(negedge clk);
        $display("cursor blink done");
    endtask

    task automatic test_invalid_reset;
        logic held;
        start_entry(17'h198B8);
        n_checks++;
        if (digits !== 24'h003456) begin
            n_fail++;
            $display("FAIL invalid_hour: digits=%h expected 003456", digits);
        end
        time_reset_n = 1'b0;
        entry_start  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.time_in, bus.time_ow, edit_active, cursor, digits, entry_timeout, cursor_blank}
                !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_mid_edit: time_in=%h active=%b cursor=%0d digits=%h expected all 0",
                     bus.time_in, edit_active, cursor, digits);
        end
        @(negedge clk);
        time_reset_n = 1'b1;
        held = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) entry_start = 1'b0;
            @(negedge clk);
            held = held | edit_active;
        end
        n_checks++;
        if (held !== 1'b0) begin
            n_fail++;
            $display("FAIL start_held: edit_active seen=%b expected 0", held);
        end
        start_entry(17'h0C8B8);
        n_checks++;
        if (digits !== 24'h123456 || edit_active !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: digits=%h active=%b expected 123456 1", digits, edit_active);
        end
        press(B_CANCEL);
        @(negedge clk);
        $display("invalid load and reset done");
    endtask

    initial begin
        time_reset_n = 1'b0;
        entry_start  = 1'b0;
        digit_inc    = 1'b0;
        digit_dec    = 1'b0;
        digit_next   = 1'b0;
        entry_cancel = 1'b0;
        bus.cur_time = 17'd0;
        test_reset();
        test_basic();
        test_clamp();
        test_wrap();
        test_abort();
        test_blink();
        test_invalid_reset();
        n_checks++;
        if (exp_q.size() != 0 || ow_count != 3) begin
            n_fail++;
            $display("FAIL write_count: writes=%0d pending=%0d expected 3 0", ow_count, exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
